// File: rtl/usb_command_decoder.sv
// USB command word decoder: single-word configuration opcodes, two-word limit
// loads with a data timeout, and run control for normal and sweep acquisition.
module usb_command_decoder #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd50000
) (
  input  logic        Clk,
  input  logic        reset_n,
  input  logic [15:0] UsbCmdData,
  input  logic        UsbCmdData_en,
  input  logic        SweepTestDone,
  output logic [1:0]  ModeSelect,
  output logic [1:0]  DacSelect,
  output logic [9:0]  StartDac,
  output logic [9:0]  EndDac,
  output logic [15:0] MaxPackageNumber,
  output logic [15:0] CPT_MAX,
  output logic [15:0] CounterMax,
  output logic [5:0]  SingleTestChannel,
  output logic        SingleOr64Channel,
  output logic        CTestOrInput,
  output logic        TrigEffiOrCountEffi,
  output logic        NormalAcqStartStop,
  output logic        SweepTestStartStop,
  output logic        UsbForceMicrorocAcqReset,
  output logic        CmdError,
  output logic [7:0]  ErrorCount
);

  typedef enum logic {
    ST_IDLE,
    ST_WAIT_DATA
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [15:0] r_timeout, w_timeout_nxt;
  logic [1:0]  r_target, w_target_nxt;

  logic [1:0]  r_mode, w_mode_nxt;
  logic [1:0]  r_dac_sel, w_dac_sel_nxt;
  logic [9:0]  r_start_dac, w_start_dac_nxt;
  logic [9:0]  r_end_dac, w_end_dac_nxt;
  logic [15:0] r_max_pkg, w_max_pkg_nxt;
  logic [15:0] r_cpt_max, w_cpt_max_nxt;
  logic [15:0] r_cnt_max, w_cnt_max_nxt;
  logic [5:0]  r_channel, w_channel_nxt;
  logic        r_or64, w_or64_nxt;
  logic        r_ctest, w_ctest_nxt;
  logic        r_trig, w_trig_nxt;
  logic        r_normal, w_normal_nxt;
  logic        r_sweep, w_sweep_nxt;
  logic        r_acq_rst, w_acq_rst_nxt;
  logic        r_err, w_err_nxt;
  logic [7:0]  r_err_cnt, w_err_cnt_nxt;

  logic [3:0]  w_opcode;
  logic [11:0] w_payload;

  assign w_opcode  = UsbCmdData[15:12];
  assign w_payload = UsbCmdData[11:0];

  always_comb begin
    w_state_nxt     = r_state;
    w_timeout_nxt   = r_timeout;
    w_target_nxt    = r_target;
    w_mode_nxt      = r_mode;
    w_dac_sel_nxt   = r_dac_sel;
    w_start_dac_nxt = r_start_dac;
    w_end_dac_nxt   = r_end_dac;
    w_max_pkg_nxt   = r_max_pkg;
    w_cpt_max_nxt   = r_cpt_max;
    w_cnt_max_nxt   = r_cnt_max;
    w_channel_nxt   = r_channel;
    w_or64_nxt      = r_or64;
    w_ctest_nxt     = r_ctest;
    w_trig_nxt      = r_trig;
    w_normal_nxt    = r_normal;
    w_sweep_nxt     = r_sweep;
    w_acq_rst_nxt   = 1'b0;
    w_err_nxt       = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (UsbCmdData_en) begin
          unique case (w_opcode)
            4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7: begin
              // Configuration is frozen for the whole sweep run.
              if (r_sweep) begin
                w_err_nxt = 1'b1;
              end else begin
                unique case (w_opcode)
                  4'h1: begin
                    w_mode_nxt    = w_payload[1:0];
                    w_dac_sel_nxt = w_payload[3:2];
                  end
                  4'h2: w_start_dac_nxt = w_payload[9:0];
                  4'h3: w_end_dac_nxt   = w_payload[9:0];
                  4'h4: begin
                    w_channel_nxt = w_payload[5:0];
                    w_or64_nxt    = w_payload[6];
                    w_ctest_nxt   = w_payload[7];
                    w_trig_nxt    = w_payload[8];
                  end
                  default: begin
                    w_state_nxt   = ST_WAIT_DATA;
                    w_timeout_nxt = '0;
                    w_target_nxt  = w_opcode[1:0];
                  end
                endcase
              end
            end
            4'hA: begin
              if (w_payload[0] && r_sweep) w_err_nxt = 1'b1;
              if (w_payload[1]) begin
                w_normal_nxt = 1'b0;
              end else if (w_payload[0] && !r_sweep) begin
                w_normal_nxt = 1'b1;
              end
              if (w_payload[2] && !r_sweep) begin
                if (r_start_dac > r_end_dac) w_err_nxt = 1'b1;
                else                         w_sweep_nxt = 1'b1;
              end
              if (w_payload[3]) w_sweep_nxt = 1'b0;
              w_acq_rst_nxt = w_payload[4];
            end
            default: w_err_nxt = 1'b1;
          endcase
        end
      end

      ST_WAIT_DATA: begin
        if (UsbCmdData_en) begin
          unique case (r_target)
            2'd1:    w_max_pkg_nxt = UsbCmdData;
            2'd2:    w_cpt_max_nxt = UsbCmdData;
            default: w_cnt_max_nxt = UsbCmdData;
          endcase
          w_state_nxt   = ST_IDLE;
          w_timeout_nxt = '0;
        end else if (r_timeout == TIMEOUT_CYCLES - 16'd1) begin
          w_state_nxt   = ST_IDLE;
          w_timeout_nxt = '0;
          w_err_nxt     = 1'b1;
        end else begin
          w_timeout_nxt = r_timeout + 16'd1;
        end
      end

      default: w_state_nxt = ST_IDLE;
    endcase

    // Done from the controller overrides any start accepted in the same cycle.
    if (SweepTestDone) w_sweep_nxt = 1'b0;

    w_err_cnt_nxt = r_err_cnt;
    if (w_err_nxt && (r_err_cnt != 8'hFF)) w_err_cnt_nxt = r_err_cnt + 8'd1;
  end

  always_ff @(posedge Clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_timeout   <= '0;
      r_target    <= '0;
      r_mode      <= '0;
      r_dac_sel   <= '0;
      r_start_dac <= '0;
      r_end_dac   <= '1;
      r_max_pkg   <= 16'd1000;
      r_cpt_max   <= 16'd1000;
      r_cnt_max   <= 16'd1000;
      r_channel   <= '0;
      r_or64      <= 1'b0;
      r_ctest     <= 1'b0;
      r_trig      <= 1'b0;
      r_normal    <= 1'b0;
      r_sweep     <= 1'b0;
      r_acq_rst   <= 1'b0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_timeout   <= w_timeout_nxt;
      r_target    <= w_target_nxt;
      r_mode      <= w_mode_nxt;
      r_dac_sel   <= w_dac_sel_nxt;
      r_start_dac <= w_start_dac_nxt;
      r_end_dac   <= w_end_dac_nxt;
      r_max_pkg   <= w_max_pkg_nxt;
      r_cpt_max   <= w_cpt_max_nxt;
      r_cnt_max   <= w_cnt_max_nxt;
      r_channel   <= w_channel_nxt;
      r_or64      <= w_or64_nxt;
      r_ctest     <= w_ctest_nxt;
      r_trig      <= w_trig_nxt;
      r_normal    <= w_normal_nxt;
      r_sweep     <= w_sweep_nxt;
      r_acq_rst   <= w_acq_rst_nxt;
      r_err       <= w_err_nxt;
      r_err_cnt   <= w_err_cnt_nxt;
    end
  end

  assign ModeSelect               = r_mode;
  assign DacSelect                = r_dac_sel;
  assign StartDac                 = r_start_dac;
  assign EndDac                   = r_end_dac;
  assign MaxPackageNumber         = r_max_pkg;
  assign CPT_MAX                  = r_cpt_max;
  assign CounterMax               = r_cnt_max;
  assign SingleTestChannel        = r_channel;
  assign SingleOr64Channel        = r_or64;
  assign CTestOrInput             = r_ctest;
  assign TrigEffiOrCountEffi      = r_trig;
  assign NormalAcqStartStop       = r_normal;
  assign SweepTestStartStop       = r_sweep;
  assign UsbForceMicrorocAcqReset = r_acq_rst;
  assign CmdError                 = r_err;
  assign ErrorCount               = r_err_cnt;

endmodule
